// File: rtl/axi_lite_mem_arbiter_if.sv
// AXI-lite bus bundle shared by the two arbiter masters and the SRAM slave port.
// Handshake: a transfer completes on a posedge where valid && ready are both 1; the source holds valid and payload until then.
interface axi_lite_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic              bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI-lite SRAM between the IFU (m0, read-only) and the LSU (m1, read/write).
// Reads are round-robin arbitrated; one LSU write is tracked and LSU reads wait for it to finish.
module axi_lite_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int STRB_W    = 32,
  parameter bit INIT_PRIO = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_lite_mem_arbiter_if.slave  m0,
  axi_lite_mem_arbiter_if.slave  m1,
  axi_lite_mem_arbiter_if.master s,
  output logic [1:0]             dbg_rstate,
  output logic [1:0]             dbg_wstate
);
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  logic [1:0]        rstate, rstate_nxt;
  logic [1:0]        wstate, wstate_nxt;
  logic              grant, grant_nxt;
  logic              last_grant, last_grant_nxt;
  logic              req0, req1;
  logic              in_raddr, in_rdata;
  logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [ADDR_W-1:0] araddr_sel;
  logic [DATA_W-1:0] rdata_bus;
  logic [STRB_W-1:0] wstrb_bus;
  logic              unused_m0_write;

  // An LSU read also waits when its write address rises in the same cycle.
  assign req0 = m0.arvalid;
  assign req1 = m1.arvalid && (wstate == W_IDLE) && !m1.awvalid;

  assign in_raddr = (rstate == R_ADDR);
  assign in_rdata = (rstate == R_DATA);

  // Read address channel
  assign araddr_sel = grant ? m1.araddr : m0.araddr;
  assign s.araddr   = in_raddr ? araddr_sel : '0;
  assign s.arvalid  = in_raddr && (grant ? m1.arvalid : m0.arvalid);
  assign m0.arready = in_raddr && !grant && s.arready;
  assign m1.arready = in_raddr &&  grant && s.arready;

  // Read data channel: data always flows, only valid/ready are gated
  assign rdata_bus  = s.rdata;
  assign m0.rdata   = rdata_bus;
  assign m1.rdata   = rdata_bus;
  assign m0.rresp   = s.rresp;
  assign m1.rresp   = s.rresp;
  assign s.rready   = in_rdata && (grant ? m1.rready : m0.rready);
  assign m0.rvalid  = in_rdata && !grant && s.rvalid;
  assign m1.rvalid  = in_rdata &&  grant && s.rvalid;

  // Write channels, LSU only
  assign wstrb_bus  = m1.wstrb;
  assign s.awaddr   = m1.awaddr;
  assign s.wdata    = m1.wdata;
  assign s.wstrb    = wstrb_bus;
  assign s.awvalid  = (wstate == W_ADDR) && m1.awvalid;
  assign m1.awready = (wstate == W_ADDR) && s.awready;
  assign s.wvalid   = (wstate == W_DATA) && m1.wvalid;
  assign m1.wready  = (wstate == W_DATA) && s.wready;
  assign m1.bvalid  = (wstate == W_RESP) && s.bvalid;
  assign s.bready   = (wstate == W_RESP) && m1.bready;
  assign m1.bresp   = s.bresp;

  // The IFU never writes
  assign m0.awready = 1'b0;
  assign m0.wready  = 1'b0;
  assign m0.bvalid  = 1'b0;
  assign m0.bresp   = 1'b0;
  assign unused_m0_write = ^{m0.awaddr, m0.awvalid, m0.wdata, m0.wstrb, m0.wvalid, m0.bready};

  assign ar_hs = s.arvalid && s.arready;
  assign r_hs  = s.rvalid  && s.rready;
  assign aw_hs = s.awvalid && s.awready;
  assign w_hs  = s.wvalid  && s.wready;
  assign b_hs  = s.bvalid  && s.bready;

  always_comb begin
    rstate_nxt     = rstate;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (rstate)
      R_IDLE: begin
        if (req0 || req1) begin
          grant_nxt      = (req0 && req1) ? !last_grant : req1;
          last_grant_nxt = grant_nxt;
          rstate_nxt     = R_ADDR;
        end
      end
      R_ADDR:  if (ar_hs) rstate_nxt = R_DATA;
      R_DATA:  if (r_hs)  rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE:  if (m1.awvalid) wstate_nxt = W_ADDR;
      W_ADDR:  if (aw_hs)      wstate_nxt = W_DATA;
      W_DATA:  if (w_hs)       wstate_nxt = W_RESP;
      W_RESP:  if (b_hs)       wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate     <= R_IDLE;
      wstate     <= W_IDLE;
      grant      <= 1'b0;
      last_grant <= !INIT_PRIO;
    end else begin
      rstate     <= rstate_nxt;
      wstate     <= wstate_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  assign dbg_rstate = rstate;
  assign dbg_wstate = wstate;
endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed bench for axi_lite_mem_arbiter: a per-cycle read vector table plus hand-written
// sequences for write ordering, same-cycle AR/AW, read/write overlap and mid-transfer reset.
module tb_axi_lite_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 32;
  localparam logic [31:0] M0_ADDR = 32'h8000_0000;
  localparam logic [31:0] M1_ADDR = 32'h8000_0100;

  localparam logic [11:0] F_M0_ARREADY = 12'h800;
  localparam logic [11:0] F_M1_ARREADY = 12'h400;
  localparam logic [11:0] F_S_ARVALID  = 12'h200;
  localparam logic [11:0] F_M0_RVALID  = 12'h100;
  localparam logic [11:0] F_M1_RVALID  = 12'h080;
  localparam logic [11:0] F_S_RREADY   = 12'h040;
  localparam logic [11:0] F_M1_AWREADY = 12'h020;
  localparam logic [11:0] F_M1_WREADY  = 12'h010;
  localparam logic [11:0] F_M1_BVALID  = 12'h008;
  localparam logic [11:0] F_S_AWVALID  = 12'h004;
  localparam logic [11:0] F_S_WVALID   = 12'h002;
  localparam logic [11:0] F_S_BREADY   = 12'h001;

  typedef struct {
    logic [5:0]  in_bits;   // {m0_arvalid, m1_arvalid, m0_rready, m1_rready, s_arready, s_rvalid}
    logic [31:0] s_rdata;
    logic [11:0] exp_flags;
    logic [31:0] exp_araddr;
  } vec_t;

  localparam int NV = 17;

  logic        clk;
  logic        rst;
  logic [1:0]  dbg_rstate;
  logic [1:0]  dbg_wstate;
  logic [11:0] flags;
  logic [31:0] sram_word;
  int          checks;
  int          errors;
  vec_t        vecs [NV];

  axi_lite_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) m0_bus ();
  axi_lite_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) m1_bus ();
  axi_lite_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) s_bus ();

  axi_lite_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .INIT_PRIO(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus),
    .dbg_rstate(dbg_rstate), .dbg_wstate(dbg_wstate)
  );

  assign flags = {m0_bus.arready, m1_bus.arready, s_bus.arvalid, m0_bus.rvalid, m1_bus.rvalid,
                  s_bus.rready, m1_bus.awready, m1_bus.wready, m1_bus.bvalid, s_bus.awvalid,
                  s_bus.wvalid, s_bus.bready};

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] in_bits, input logic [31:0] rd,
                              input logic [11:0] ef, input logic [31:0] ea);
    vec_t v;
    v.in_bits    = in_bits;
    v.s_rdata    = rd;
    v.exp_flags  = ef;
    v.exp_araddr = ea;
    return v;
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    m0_bus.araddr = M0_ADDR; m0_bus.arvalid = 1'b0; m0_bus.rready = 1'b0;
    m0_bus.awaddr = '0; m0_bus.awvalid = 1'b0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
    m0_bus.wvalid = 1'b0; m0_bus.bready = 1'b0;
    m1_bus.araddr = M1_ADDR; m1_bus.arvalid = 1'b0; m1_bus.rready = 1'b0;
    m1_bus.awaddr = M1_ADDR; m1_bus.awvalid = 1'b0; m1_bus.wdata = 32'hDEAD_BEEF;
    m1_bus.wstrb = 32'hF; m1_bus.wvalid = 1'b0; m1_bus.bready = 1'b0;
    s_bus.arready = 1'b0; s_bus.rdata = '0; s_bus.rresp = 1'b0; s_bus.rvalid = 1'b0;
    s_bus.awready = 1'b0; s_bus.wready = 1'b0; s_bus.bresp = 1'b0; s_bus.bvalid = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    {m0_bus.arvalid, m1_bus.arvalid, m0_bus.rready, m1_bus.rready, s_bus.arready, s_bus.rvalid} = v.in_bits;
    s_bus.rdata = v.s_rdata;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sram_word = '0;
    rst = 1'b0;
    idle_inputs();

    vecs[0]  = mk(6'b110010, 32'h0,         12'h0,                       32'h0);
    vecs[1]  = mk(6'b110010, 32'h0,         F_S_ARVALID | F_M1_ARREADY,  M1_ADDR);
    vecs[2]  = mk(6'b101101, 32'h1111_1111, F_M1_RVALID | F_S_RREADY,    32'h0);
    vecs[3]  = mk(6'b110001, 32'h0,         12'h0,                       32'h0);
    vecs[4]  = mk(6'b110010, 32'h0,         F_S_ARVALID | F_M0_ARREADY,  M0_ADDR);
    vecs[5]  = mk(6'b011101, 32'h2222_2222, F_M0_RVALID | F_S_RREADY,    32'h0);
    vecs[6]  = mk(6'b110000, 32'h0,         12'h0,                       32'h0);
    vecs[7]  = mk(6'b110000, 32'h0,         F_S_ARVALID,                 M1_ADDR);
    vecs[8]  = mk(6'b110010, 32'h0,         F_S_ARVALID | F_M1_ARREADY,  M1_ADDR);
    vecs[9]  = mk(6'b101001, 32'h3333_3333, F_M1_RVALID,                 32'h0);
    vecs[10] = mk(6'b101101, 32'h3333_3333, F_M1_RVALID | F_S_RREADY,    32'h0);
    vecs[11] = mk(6'b100000, 32'h0,         12'h0,                       32'h0);
    vecs[12] = mk(6'b100000, 32'h0,         F_S_ARVALID,                 M0_ADDR);
    vecs[13] = mk(6'b100010, 32'h0,         F_S_ARVALID | F_M0_ARREADY,  M0_ADDR);
    vecs[14] = mk(6'b001000, 32'h0000_0413, F_S_RREADY,                  32'h0);
    vecs[15] = mk(6'b001001, 32'h0000_0413, F_M0_RVALID | F_S_RREADY,    32'h0);
    vecs[16] = mk(6'b000011, 32'h0,         12'h0,                       32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset flags", flags, 12'h0);
    check("reset rstate", dbg_rstate, 2'd0);
    check("reset wstate", dbg_wstate, 2'd0);
    rst = 1'b1;

    // Read vector table; write-side slave readies held high to expose any leakage
    s_bus.awready = 1'b1; s_bus.wready = 1'b1; s_bus.bvalid = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply_vec(vecs[i]);
      #1;
      check($sformatf("vec%0d flags", i), flags, vecs[i].exp_flags);
      check($sformatf("vec%0d araddr", i), s_bus.araddr, vecs[i].exp_araddr);
      if ((vecs[i].exp_flags & (F_M0_RVALID | F_M1_RVALID)) != 12'h0) begin
        check($sformatf("vec%0d m0_rdata", i), m0_bus.rdata, vecs[i].s_rdata);
        check($sformatf("vec%0d m1_rdata", i), m1_bus.rdata, vecs[i].s_rdata);
      end
    end

    // LSU write, then a read of the same address one cycle later
    @(negedge clk);
    idle_inputs();
    m1_bus.awvalid = 1'b1; m1_bus.wvalid = 1'b1; m1_bus.bready = 1'b1;
    s_bus.awready = 1'b1; s_bus.wready = 1'b1;
    #1 check("raw idle", flags, 12'h0);
    @(negedge clk);
    m1_bus.arvalid = 1'b1;
    #1 check("raw aw", flags, F_S_AWVALID | F_M1_AWREADY);
    check("raw awaddr", s_bus.awaddr, M1_ADDR);
    @(negedge clk);
    m1_bus.awvalid = 1'b0;
    #1 check("raw w", flags, F_S_WVALID | F_M1_WREADY);
    check("raw wdata", s_bus.wdata, 32'hDEAD_BEEF);
    check("raw wstrb", s_bus.wstrb, 32'hF);
    sram_word = s_bus.wdata;
    @(negedge clk);
    m1_bus.wvalid = 1'b0;
    #1 check("raw b wait", flags, F_S_BREADY);
    @(negedge clk);
    s_bus.bvalid = 1'b1;
    #1 check("raw b", flags, F_M1_BVALID | F_S_BREADY);
    check("raw read held", dbg_rstate, 2'd0);
    @(negedge clk);
    s_bus.bvalid = 1'b0;
    #1 check("raw arb", flags, 12'h0);
    @(negedge clk);
    s_bus.arready = 1'b1;
    #1 check("raw ar", flags, F_S_ARVALID | F_M1_ARREADY);
    check("raw araddr", s_bus.araddr, M1_ADDR);
    @(negedge clk);
    m1_bus.arvalid = 1'b0; m1_bus.rready = 1'b1; s_bus.rvalid = 1'b1; s_bus.rdata = sram_word;
    #1 check("raw r", flags, F_M1_RVALID | F_S_RREADY);
    check("raw rdata", m1_bus.rdata, 32'hDEAD_BEEF);

    // AR and AW from the LSU rising together: write first
    @(negedge clk);
    idle_inputs();
    m1_bus.arvalid = 1'b1; m1_bus.awvalid = 1'b1; m1_bus.wvalid = 1'b1; m1_bus.bready = 1'b1;
    #1 check("same idle", flags, 12'h0);
    @(negedge clk);
    #1 check("same aw stall", flags, F_S_AWVALID);
    check("same read held", dbg_rstate, 2'd0);
    @(negedge clk);
    s_bus.awready = 1'b1;
    #1 check("same aw", flags, F_S_AWVALID | F_M1_AWREADY);
    @(negedge clk);
    m1_bus.awvalid = 1'b0; s_bus.wready = 1'b1;
    #1 check("same w", flags, F_S_WVALID | F_M1_WREADY);
    @(negedge clk);
    m1_bus.wvalid = 1'b0; s_bus.bvalid = 1'b1;
    #1 check("same b", flags, F_M1_BVALID | F_S_BREADY);
    @(negedge clk);
    s_bus.bvalid = 1'b0;
    #1 check("same arb", flags, 12'h0);
    @(negedge clk);
    s_bus.arready = 1'b1;
    #1 check("same ar", flags, F_S_ARVALID | F_M1_ARREADY);
    @(negedge clk);
    m1_bus.arvalid = 1'b0; m1_bus.rready = 1'b1; s_bus.rvalid = 1'b1;
    #1 check("same r", flags, F_M1_RVALID | F_S_RREADY);

    // IFU read overlapping an LSU write
    @(negedge clk);
    idle_inputs();
    m0_bus.arvalid = 1'b1; m1_bus.awvalid = 1'b1; m1_bus.wvalid = 1'b1; m1_bus.bready = 1'b1;
    s_bus.arready = 1'b1; s_bus.awready = 1'b1; s_bus.wready = 1'b1;
    #1 check("ovl idle", flags, 12'h0);
    @(negedge clk);
    #1 check("ovl ar aw", flags, F_S_ARVALID | F_M0_ARREADY | F_S_AWVALID | F_M1_AWREADY);
    check("ovl araddr", s_bus.araddr, M0_ADDR);
    @(negedge clk);
    m0_bus.arvalid = 1'b0; m1_bus.awvalid = 1'b0; m0_bus.rready = 1'b1;
    s_bus.rvalid = 1'b1; s_bus.bvalid = 1'b1; s_bus.rdata = 32'h0000_0513;
    #1 check("ovl r w", flags, F_M0_RVALID | F_S_RREADY | F_S_WVALID | F_M1_WREADY);
    check("ovl rdata", m0_bus.rdata, 32'h0000_0513);
    @(negedge clk);
    m1_bus.wvalid = 1'b0;
    #1 check("ovl b", flags, F_M1_BVALID | F_S_BREADY);
    @(negedge clk);
    #1 check("ovl done", flags, 12'h0);

    // Reset in R_DATA with s_rvalid high and a write stuck in W_ADDR
    @(negedge clk);
    idle_inputs();
    m0_bus.arvalid = 1'b1; m1_bus.awvalid = 1'b1; s_bus.arready = 1'b1;
    #1 check("rst pre idle", flags, 12'h0);
    @(negedge clk);
    #1 check("rst pre ar", flags, F_S_ARVALID | F_M0_ARREADY | F_S_AWVALID);
    @(negedge clk);
    m0_bus.arvalid = 1'b0; s_bus.rvalid = 1'b1;
    #1 check("rst pre r", flags, F_M0_RVALID | F_S_AWVALID);
    #2 rst = 1'b0;
    #1 check("rst async flags", flags, 12'h0);
    check("rst async rstate", dbg_rstate, 2'd0);
    check("rst async wstate", dbg_wstate, 2'd0);
    @(negedge clk);
    m0_bus.arvalid = 1'b1; m1_bus.arvalid = 1'b1; m1_bus.awvalid = 1'b0; s_bus.rvalid = 1'b0;
    rst = 1'b1;
    #1 check("rst first cycle", flags, 12'h0);
    @(negedge clk);
    #1 check("rst init prio", flags, F_S_ARVALID | F_M1_ARREADY);
    check("rst init araddr", s_bus.araddr, M1_ADDR);

    @(negedge clk);
    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_mem_arbiter.md
Name: axi_lite_mem_arbiter

Overview:
- Shares the single AXI-lite SRAM slave (`ysyx_25010008_SRAM`) between two masters: the IFU (m0, read-only) and the LSU (m1, read + write).
- Arbitrates the read channels between m0 and m1 with round-robin priority.
- Tracks one outstanding write from m1.
- Blocks an LSU read while an LSU write is still in flight, so read-after-write through memory stays ordered.
- Sits between the IFU/LSU and the SRAM in the core top level.

Parameters:
- ADDR_W, 32, address width of all AR/AW channels
- DATA_W, 32, data width of all R/W channels
- STRB_W, 32, wstrb width; matches the SRAM wstrb port
- INIT_PRIO, 1, master that wins the first simultaneous read request after reset (0 = IFU, 1 = LSU)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- m0_araddr / m0_arvalid / m0_arready  in/in/out  ADDR_W/1/1  IFU read address channel
- m0_rdata / m0_rresp / m0_rvalid / m0_rready  out/out/out/in  DATA_W/1/1/1  IFU read data channel
- m1_araddr / m1_arvalid / m1_arready  in/in/out  ADDR_W/1/1  LSU read address channel
- m1_rdata / m1_rresp / m1_rvalid / m1_rready  out/out/out/in  DATA_W/1/1/1  LSU read data channel
- m1_awaddr / m1_awvalid / m1_awready  in/in/out  ADDR_W/1/1  LSU write address channel
- m1_wdata / m1_wstrb / m1_wvalid / m1_wready  in/in/in/out  DATA_W/STRB_W/1/1  LSU write data channel
- m1_bresp / m1_bvalid / m1_bready  out/out/in  1/1/1  LSU write response channel
- s_araddr / s_arvalid / s_arready  out/out/in  ADDR_W/1/1  slave read address channel
- s_rdata / s_rresp / s_rvalid / s_rready  in/in/in/out  DATA_W/1/1/1  slave read data channel
- s_awaddr / s_awvalid / s_awready  out/out/in  ADDR_W/1/1  slave write address channel
- s_wdata / s_wstrb / s_wvalid / s_wready  out/out/out/in  DATA_W/STRB_W/1/1  slave write data channel
- s_bresp / s_bvalid / s_bready  in/in/out  1/1/1  slave write response channel

Behaviour:

Conventions
- A handshake completes on a posedge where valid && ready are both 1.
- Every ready and valid output is a combinational AND of the registered state with the opposite side's signal. No output is registered beyond the state.

Reset (rst = 0, asynchronous)
- rstate = R_IDLE, wstate = W_IDLE, grant = none, last_grant = !INIT_PRIO.
- All valid and ready outputs are 0 while in reset and in the first cycle after release.
- Reset taken mid-transaction abandons that transaction. Nothing is replayed; the SRAM is reset by the same network.

Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE
- R_IDLE:
  - Let req0 = m0_arvalid and req1 = m1_arvalid && (wstate == W_IDLE).
  - Only one request: grant it.
  - Both requests: grant the master != last_grant.
  - Register grant and last_grant, then go to R_ADDR. This costs 1 cycle of arbitration latency.
  - No request: stay.
- R_ADDR:
  - s_araddr = granted master's araddr; s_arvalid = granted arvalid.
  - Granted arready = s_arready; the other master's arready = 0.
  - On the s_ar handshake, go to R_DATA.
  - The master must hold arvalid; the arbiter does not re-arbitrate in this state.
- R_DATA:
  - s_rready = granted rready.
  - Granted rvalid/rdata/rresp = s_rvalid/s_rdata/s_rresp; the other master's rvalid = 0.
  - On the s_r handshake, go to R_IDLE; grant = none.
- Outside R_ADDR: s_arvalid = 0 and s_araddr = 0.
- Outside R_DATA: s_rready = 0 and both m*_rvalid = 0.
- m*_rdata holds s_rdata regardless of state; only rvalid is gated.
- Back-to-back reads: earliest next grant is the cycle after the R handshake (returns to R_IDLE, then arbitrates). Minimum 3 arbiter cycles per read plus slave latency.

Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE
- W_IDLE: on m1_awvalid, go to W_ADDR the next cycle.
- W_ADDR:
  - Pass AW through; m1_awready = s_awready.
  - On handshake, go to W_DATA.
- W_DATA:
  - Pass W through; m1_wready = s_wready.
  - On handshake, go to W_RESP.
- W_RESP:
  - Pass B through; m1_bvalid = s_bvalid; s_bready = m1_bready.
  - On handshake, go to W_IDLE.
- Each channel's ready/valid is 0 outside its own state.
- Exactly one write is outstanding. AW before W ordering is enforced.

Concurrency and ordering
- Read and write FSMs run independently. An IFU read may overlap an LSU write.
- LSU read requests are ignored while wstate != W_IDLE. The LSU read is granted no earlier than the cycle after the B handshake.
- m1_arvalid and m1_awvalid rising in the same cycle: the write starts and the read waits for the write to finish.
- A request that deasserts in R_IDLE before grant is simply not granted.

Test Plan:
- IFU read only: m0 araddr=0x8000_0000; slave returns rdata=0x0000_0413 -> m0_rvalid with 0x0000_0413; m1_rvalid stays 0; s_arvalid high exactly from the grant cycle until the handshake.
- Simultaneous m0/m1 reads right after reset, INIT_PRIO=1 -> LSU served first, IFU second; repeat both -> order IFU, LSU (round-robin alternates).
- IFU streaming requests plus one LSU request -> LSU granted on the next R_IDLE; IFU never granted twice in a row while LSU is pending.
- LSU write awaddr=0x8000_0100, wdata=0xDEADBEEF, wstrb=0xF, with m1_arvalid to the same address asserted one cycle later -> read not forwarded until after m1 bvalid handshake; read returns 0xDEADBEEF.
- IFU read concurrent with LSU write -> both complete; s_ar and s_aw handshakes may share a cycle; no cross-routing of rvalid/bvalid.
- rst pulled low in R_DATA with s_rvalid=1 -> all m*/s* valid and ready outputs 0 immediately (asynchronous); after release, first grant follows INIT_PRIO.
